// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, widths and frame helpers for the keypad scanner
package keypad_pkg;

   localparam int KEY_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_SINGLE = 2'd1,
      CLS_MULTI  = 2'd2
   } frame_class_t;

   // raw_map is laid out column-major (bit = col*4+row), so count the set bits
   function automatic frame_class_t classify(input logic [15:0] map);
      logic [4:0] ones;
      ones = 5'd0;
      for (int i = 0; i < 16; i++) begin
         ones = ones + {4'd0, map[i]};
      end
      if (ones == 5'd0) begin
         return CLS_NONE;
      end else if (ones == 5'd1) begin
         return CLS_SINGLE;
      end
      return CLS_MULTI;
   endfunction

   // Key code is row*4+col; only meaningful when exactly one bit is set
   function automatic logic [KEY_W-1:0] encode(input logic [15:0] map);
      logic [KEY_W-1:0] code;
      logic [3:0]       bit_idx;
      code = '0;
      for (int i = 0; i < 16; i++) begin
         bit_idx = 4'(i);
         if (map[i]) begin
            code = {bit_idx[1:0], bit_idx[3:2]};
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - press/release debounce FSM with key output registers
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_N = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_done,
   input  frame_class_t     frame_class,
   input  logic [KEY_W-1:0] code,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_down,
   output logic [31:0]      key_hist
);

   localparam logic [3:0] N_L = 4'(DEBOUNCE_N);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [KEY_W-1:0] cand_q, cand_d;
   logic [KEY_W-1:0] key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             key_down_q, key_down_d;
   logic [31:0]      key_hist_q, key_hist_d;
   logic             accept;
   logic [KEY_W-1:0] accept_code;
   logic [3:0]       cnt_inc;

   // Next-state and output logic; the FSM only moves on a completed frame
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cand_d      = cand_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_down_d  = key_down_q;
      key_hist_d  = key_hist_q;
      accept      = 1'b0;
      accept_code = cand_q;
      cnt_inc     = cnt_q + 4'd1;
      if (frame_done) begin
         case (state_q)
            ST_IDLE: begin
               if (frame_class == CLS_SINGLE) begin
                  cand_d = code;
                  cnt_d  = 4'd1;
                  if (N_L == 4'd1) begin
                     accept      = 1'b1;
                     accept_code = code;
                     state_d     = ST_HELD;
                  end else begin
                     state_d = ST_PRESS_WAIT;
                  end
               end
            end
            ST_PRESS_WAIT: begin
               if (frame_class == CLS_SINGLE && code == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == N_L) begin
                     accept  = 1'b1;
                     state_d = ST_HELD;
                  end
               end else begin
                  cnt_d   = 4'd0;
                  state_d = ST_IDLE;
               end
            end
            ST_HELD: begin
               // Extra keys while held are ignored; only a clean NONE frame starts release
               if (frame_class == CLS_NONE) begin
                  cnt_d = 4'd1;
                  if (N_L == 4'd1) begin
                     key_down_d = 1'b0;
                     state_d    = ST_IDLE;
                  end else begin
                     state_d = ST_RELEASE_WAIT;
                  end
               end
            end
            ST_RELEASE_WAIT: begin
               if (frame_class == CLS_NONE) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == N_L) begin
                     key_down_d = 1'b0;
                     state_d    = ST_IDLE;
                  end
               end else begin
                  state_d = ST_HELD;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      if (accept) begin
         key_code_d  = accept_code;
         key_valid_d = 1'b1;
         key_down_d  = 1'b1;
         key_hist_d  = {key_hist_q[31-KEY_W:0], accept_code};
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         cand_q      <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
         key_hist_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_down_q  <= key_down_d;
         key_hist_q  <= key_hist_d;
      end
   end

   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_down  = key_down_q;
   assign key_hist  = key_hist_q;

endmodule

// File: rtl/keypad_scan4x4.sv
// rtl/keypad_scan4x4.sv - 4x4 keypad column scanner, row sampler and frame classifier
module keypad_scan4x4
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV_W = 15,
   parameter int DEBOUNCE_N = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       row_n,
   output logic [3:0]       col_n,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_down,
   output logic [31:0]      key_hist
);

   logic [SCAN_DIV_W-1:0] div_q, div_d;
   logic [1:0]            col_idx_q, col_idx_d;
   logic [3:0]            row_meta_q, row_meta_d;
   logic [3:0]            row_sync_q, row_sync_d;
   logic [15:0]           raw_map_q, raw_map_d;
   logic                  frame_done_q, frame_done_d;
   logic                  tick;
   frame_class_t          frame_class;
   logic [KEY_W-1:0]      frame_code;

   // Divider, column stepping, row synchronizer and raw_map capture
   always_comb begin
      tick         = &div_q;
      div_d        = div_q + SCAN_DIV_W'(1);
      col_idx_d    = col_idx_q;
      raw_map_d    = raw_map_q;
      frame_done_d = 1'b0;
      row_meta_d   = row_n;
      row_sync_d   = row_meta_q;
      if (tick) begin
         // Sample the column that has been driven for the whole tick period, then move on
         raw_map_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
         col_idx_d    = col_idx_q + 2'd1;
         frame_done_d = (col_idx_q == 2'd3);
      end
   end

   // Scan-side registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q        <= '0;
         col_idx_q    <= 2'd0;
         row_meta_q   <= 4'hF;
         row_sync_q   <= 4'hF;
         raw_map_q    <= 16'd0;
         frame_done_q <= 1'b0;
      end else begin
         div_q        <= div_d;
         col_idx_q    <= col_idx_d;
         row_meta_q   <= row_meta_d;
         row_sync_q   <= row_sync_d;
         raw_map_q    <= raw_map_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign col_n       = ~(4'b0001 << col_idx_q);
   assign frame_class = classify(raw_map_q);
   assign frame_code  = encode(raw_map_q);

   keypad_debounce #(
      .DEBOUNCE_N (DEBOUNCE_N)
   ) u_debounce (
      .clk         (clk),
      .rst         (rst),
      .frame_done  (frame_done_q),
      .frame_class (frame_class),
      .code        (frame_code),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_down    (key_down),
      .key_hist    (key_hist)
   );

endmodule

// File: tb/tb_keypad_scan4x4.sv
// tb/tb_keypad_scan4x4.sv - scoreboard bench for the 4x4 keypad scanner
module tb_keypad_scan4x4;

   localparam int FRAME = 16;

   typedef struct packed {
      logic [3:0]  code;
      logic [31:0] hist;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_down;
   logic [31:0] key_hist;
   logic [15:0] pressed;

   exp_t        exp_q[$];
   logic [31:0] shadow_hist;
   int          checks;
   int          failures;
   int          strobes;

   always #5 clk = ~clk;

   // Keypad model: a pressed key pulls its row low while its column is driven low
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
         end
      end
   end

   keypad_scan4x4 #(
      .SCAN_DIV_W (2),
      .DEBOUNCE_N (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down),
      .key_hist  (key_hist)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic expect_key(input logic [3:0] c);
      exp_t e;
      shadow_hist = {shadow_hist[27:0], c};
      e.code = c;
      e.hist = shadow_hist;
      exp_q.push_back(e);
   endtask

   task automatic wait_frames(input int n);
      repeat (n * FRAME) @(negedge clk);
   endtask

   // Monitor: every strobe must match the oldest expected key
   always @(negedge clk) begin
      exp_t e;
      if (!rst && key_valid) begin
         strobes++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual=%h required=none", key_code);
         end else begin
            e = exp_q.pop_front();
            check("strobe_code", key_code, e.code);
            check("strobe_hist", key_hist, e.hist);
            check("strobe_down", key_down, 1);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int t;
      int n;
      logic [3:0] exp_col;
      checks      = 0;
      failures    = 0;
      strobes     = 0;
      shadow_hist = 32'd0;
      pressed     = 16'd0;
      rst         = 1'b1;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_col_n", col_n, 4'b1110);
      check("rst_key_code", key_code, 0);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_down", key_down, 0);
      check("rst_key_hist", key_hist, 0);
      rst = 1'b0;

      // Column walk: one step every 4 clocks
      repeat (2) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         exp_col = ~(4'b0001 << (k % 4));
         check("col_walk", col_n, exp_col);
         repeat (4) @(negedge clk);
      end

      // Single press of row2/col1
      base = strobes;
      expect_key(4'h9);
      pressed[9] = 1'b1;
      wait_frames(6);
      check("single_strobes", strobes - base, 1);
      check("single_code", key_code, 4'h9);
      check("single_hist", key_hist, 32'h0000_0009);
      check("single_down", key_down, 1);
      pressed[9] = 1'b0;
      wait_frames(4);
      check("single_release", key_down, 0);

      // Bounce: key 5 alternates one frame on, one frame off
      base = strobes;
      for (int k = 0; k < 3; k++) begin
         pressed[5] = 1'b1;
         wait_frames(1);
         pressed[5] = 1'b0;
         wait_frames(1);
      end
      wait_frames(3);
      check("bounce_strobes", strobes - base, 0);
      check("bounce_down", key_down, 0);

      // History: keys 1..9 in sequence
      base = strobes;
      for (int k = 1; k <= 9; k++) begin
         expect_key(4'(k));
         pressed[k] = 1'b1;
         wait_frames(4);
         pressed[k] = 1'b0;
         wait_frames(4);
      end
      check("hist_strobes", strobes - base, 9);
      check("hist_value", key_hist, 32'h2345_6789);

      // Rollover: hold 3, add C, drop 3, drop all
      base = strobes;
      expect_key(4'h3);
      pressed[3] = 1'b1;
      wait_frames(4);
      check("roll_down_a", key_down, 1);
      pressed[12] = 1'b1;
      wait_frames(4);
      check("roll_down_b", key_down, 1);
      pressed[3] = 1'b0;
      wait_frames(4);
      check("roll_down_c", key_down, 1);
      check("roll_code", key_code, 4'h3);
      pressed[12] = 1'b0;
      wait_frames(4);
      check("roll_release", key_down, 0);
      check("roll_strobes", strobes - base, 1);

      // Reset during PRESS_WAIT, key kept held across reset
      t = 0;
      while (col_n != 4'b0111 && t < 64) begin
         @(negedge clk);
         t++;
      end
      while (col_n != 4'b1110 && t < 64) begin
         @(negedge clk);
         t++;
      end
      check("align_timeout", (t < 64), 1);
      base = strobes;
      pressed[6] = 1'b1;
      repeat (24) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_strobes", strobes - base, 0);
      check("midrst_col_n", col_n, 4'b1110);
      check("midrst_hist", key_hist, 0);
      check("midrst_down", key_down, 0);
      exp_q.delete();
      shadow_hist = 32'd0;
      expect_key(4'h6);
      rst = 1'b0;
      n = 0;
      while (!key_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n < 32 || n > 35) begin
         failures++;
         $display("FAIL midrst_latency actual=%0d required=32..35", n);
      end
      @(negedge clk);
      check("midrst_strobes_after", strobes - base, 1);
      pressed[6] = 1'b0;
      wait_frames(4);
      check("midrst_release", key_down, 0);
      check("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_scan4x4.md
# keypad_scan4x4

Matrix-keypad input front end for the board: drives a 4×4 keypad one column at a time, samples the rows, and debounces the result. Each accepted press produces one hex key code and a one-cycle strobe. It also maintains a 32-bit shift history of the last eight keys, in a format that connects directly to the hex input of the seven-segment display driver. It is the input-side counterpart of the multiplexed display scanner and shares its scan-rate scheme.

## Interface
Parameters:
- SCAN_DIV_W, 15: width of the scan divider; one column step every 2^SCAN_DIV_W clocks.
- DEBOUNCE_N, 4: number of consecutive identical frames required to accept a press or a release (range 1–15).

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- row_n  input  4  keypad rows; asynchronous, pulled up, active-low.
- col_n  output  4  column drive; exactly one bit low at a time.
- key_code  output  4  last accepted key, encoded as row*4+col.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_down  output  1  high from press acceptance until release acceptance.
- key_hist  output  32  history of the last 8 codes; newest code in [3:0].

## Operation
- **Scan divider.** Free-running SCAN_DIV_W-bit counter. `tick` is asserted when the counter is all ones; the counter wraps to 0.
- **Column index.** col_idx (2 bits) advances on each tick and wraps 3→0. col_n = ~(1<<col_idx).
- **Row synchronizer.** row_n passes through a 2-flop synchronizer. On each tick, the synchronized value is captured into raw_map[col_idx*4 +: 4] as active-high bits, before col_idx advances. Each column is therefore driven for a full tick period before it is sampled.
- **Frame completion.** A tick with col_idx==3 completes a frame. frame_done is a registered pulse one cycle later. Classification of raw_map:
  - NONE: zero bits set.
  - SINGLE(c): exactly one bit set; c = row*4+col.
  - MULTI: two or more bits set.
- **Debounce FSM.** States, with frames counted by a 4-bit counter. The FSM changes state only on frame_done.
  - IDLE: SINGLE(c) → PRESS_WAIT with cand=c, cnt=1. If DEBOUNCE_N==1, accept immediately. NONE or MULTI → stay in IDLE.
  - PRESS_WAIT: SINGLE(cand) → cnt+1; when cnt reaches DEBOUNCE_N, go to HELD and accept. Any other class → IDLE.
  - HELD: NONE → RELEASE_WAIT with cnt=1. SINGLE or MULTI → stay in HELD. There is no auto-repeat, and a second key pressed while holding is ignored.
  - RELEASE_WAIT: NONE → cnt+1; reaching DEBOUNCE_N → IDLE and key_down=0. SINGLE or MULTI → HELD, with no new strobe.
- **Accept action.** key_code←cand; key_valid=1 for one cycle; key_down←1; key_hist←{key_hist[27:0], cand}.
- **Rollover and ghosting.** MULTI never produces a strobe, and no ghost-key suppression is done beyond this rule.

## Timing
- Reset values: col_n=4'b1110, col_idx=0, divider=0, synchronizer flops=4'hF, raw_map=0, state=IDLE, cnt=0, key_code=0, key_valid=0, key_down=0, key_hist=0.
- A frame lasts 4·2^SCAN_DIV_W cycles.
- Latency from a stable press present for the whole first counted frame to key_valid: DEBOUNCE_N frames, plus 1 cycle (frame_done), plus 1 cycle (registered outputs).
- key_valid, key_code, key_down and key_hist all update on the same edge.
- Release latency: DEBOUNCE_N frames + 2 cycles after the last frame that saw the key.
- Reset asserted mid-scan or mid-debounce returns everything to the reset values immediately. A press still held after reset must complete a full debounce again.
- row_n may change at any time. Only the synchronized sample taken at the tick matters.

## Structure
- Shared package/header `keypad_pkg` holds:
  - FSM state encodings (IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3).
  - Frame class encodings (NONE, SINGLE, MULTI).
  - KEY_W=4.
- One sub-module, `keypad_debounce`: the FSM, the frame counter and the output registers. Inputs are frame_done, class and code. The top level contains the divider, column drive, synchronizer, raw_map and classification.

## Test plan
All scenarios use SCAN_DIV_W=2 (16-cycle frames) and DEBOUNCE_N=2, with the bench keypad model pulling the row low while the matching column is low.
- **Reset.** Hold rst 3 cycles → col_n=1110 and all outputs 0. After release, col_n steps 1110→1101→1011→0111 every 4 cycles.
- **Single press.** Press row2/col1 for 6 frames → exactly one key_valid, key_code=4'h9, key_hist=32'h0000_0009, key_down=1. Release for 3 frames → key_down=0.
- **Bounce.** Key 5 asserted for 1 frame, absent 1 frame, repeated 3× → no key_valid.
- **History.** Press and release 1,2,3,…,9 in sequence → key_hist=32'h2345_6789. Exactly 9 strobes.
- **Rollover.** Hold key 3 (accepted), then add key C → no strobe. Release 3 while C stays → stay in HELD with no strobe. Release all → key_down=0.
- **Reset mid-debounce.** Assert rst during PRESS_WAIT → no strobe. With the key still held after reset, key_valid arrives 2 frames + 2 cycles later.
